// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  // Encoding 2 is illegal and is folded onto a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline request/response and RAM bus bundle for mem_ctrl.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              rdy;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic              mem_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              if_stall;
  logic              mem_stall;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  rdy, if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_signed,
           mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, if_stall, mem_stall,
           ram_dout, ram_a, ram_wr
  );

  modport master (
    output rdy, if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_signed,
           mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, if_stall, mem_stall,
           ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl_ld_ext.sv
// Byte/half/word zero or sign extension of a little-endian load result.
module ld_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] din,
  input  logic [1:0]  len,
  input  logic        sgn,
  output logic [31:0] dout
);

  always_comb begin
    dout = din;
    case (len)
      LEN_B:   dout = {{24{sgn & din[7]}}, din[7:0]};
      LEN_H:   dout = {{16{sgn & din[15]}}, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-serial memory controller arbitrating IF and MEM stages.
// MEM has fixed priority; transfers are sequenced one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        len_q;
  logic              sgn_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_rdata_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;

  logic              rd_st, rd_act, wr_act, issue;
  logic [ADDR_W-1:0] addr_cur;
  logic [7:0]        wbyte;
  logic [1:0]        bidx;
  logic [31:0]       nbuf;
  logic [31:0]       ext;
  logic              busy_done;

  assign rd_st    = (state == IF_RD) || (state == MEM_RD);
  assign rd_act   = rd_st && (cnt < n_q);
  assign wr_act   = (state == MEM_WR);
  assign issue    = bus.rdy && !rst && (rd_act || wr_act);
  assign addr_cur = base_q + ADDR_W'(cnt);
  assign wbyte    = wdata_q[{cnt[1:0], 3'b000} +: 8];
  assign bidx     = cnt[1:0] - 2'd1;

  // Byte landing this cycle belongs to the address issued at cnt-1.
  always_comb begin
    nbuf = buf_q;
    if (rd_st && cnt != 3'd0) nbuf[{bidx, 3'b000} +: 8] = bus.ram_din;
  end

  ld_ext u_ld_ext (
    .din  (nbuf),
    .len  (len_q),
    .sgn  (sgn_q),
    .dout (ext)
  );

  // While frozen, ram_a keeps the last issued address so the in-flight byte
  // is fetched again and is valid on ram_din in the resume cycle.
  assign bus.ram_a    = issue ? addr_cur : ram_a_q;
  assign bus.ram_dout = (issue && wr_act) ? wbyte : ram_dout_q;
  assign bus.ram_wr   = issue && wr_act;

  assign bus.if_done   = if_done_q & ~bus.if_flush;
  assign bus.mem_done  = mem_done_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_done;
  assign bus.mem_stall = bus.mem_req & ~mem_done_q;

  // Requesters still hold req during the done cycle, so no accept then.
  assign busy_done = if_done_q | mem_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      len_q       <= LEN_W;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
    end else if (bus.rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (issue) ram_a_q <= addr_cur;
      if (issue && wr_act) ram_dout_q <= wbyte;
      case (state)
        IDLE: begin
          if (!busy_done) begin
            if (bus.mem_req) begin
              base_q  <= bus.mem_addr;
              len_q   <= bus.mem_len;
              n_q     <= len_bytes(bus.mem_len);
              sgn_q   <= bus.mem_signed;
              wdata_q <= bus.mem_wdata;
              buf_q   <= '0;
              cnt     <= 3'd0;
              state   <= bus.mem_we ? MEM_WR : MEM_RD;
            end else if (bus.if_req && !bus.if_flush) begin
              base_q <= bus.if_addr;
              n_q    <= 3'd4;
              buf_q  <= '0;
              cnt    <= 3'd0;
              state  <= IF_RD;
            end
          end
        end
        IF_RD: begin
          if (bus.if_flush) begin
            cnt   <= 3'd0;
            state <= IDLE;
          end else begin
            buf_q <= nbuf;
            if (cnt == n_q) begin
              if_done_q <= 1'b1;
              if_inst_q <= nbuf;
              cnt       <= 3'd0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        MEM_RD: begin
          buf_q <= nbuf;
          if (cnt == n_q) begin
            mem_done_q  <= 1'b1;
            mem_rdata_q <= ext;
            cnt         <= 3'd0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        MEM_WR: begin
          if (cnt == n_q - 3'd1) begin
            mem_done_q <= 1'b1;
            cnt        <= 3'd0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// checked against a byte-array memory model and arithmetic load extension.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM behind the controller: 4 KiB, addresses taken modulo 4096.
  logic [7:0] ram      [4096];
  logic [7:0] seed_mem [4096];
  logic [7:0] ref_mem  [4096];
  logic       seed_en;

  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < 4096; i++) ram[i] <= seed_mem[i];
    end else if (bus.ram_wr) begin
      ram[bus.ram_a[11:0]] <= bus.ram_dout;
    end
    bus.ram_din <= ram[bus.ram_a[11:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void poke(input logic [31:0] a, input logic [7:0] d);
    seed_mem[a[11:0]] = d;
    ref_mem[a[11:0]]  = d;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian assembly of n bytes, then two's-complement reinterpretation.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ai = a + i;
      v = v + (longint'(ref_mem[ai[11:0]]) << (8 * i));
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ai = a + i;
      ref_mem[ai[11:0]] = 8'((d >> (8 * i)) & 32'hFF);
    end
  endfunction

  task automatic run_if(input logic [31:0] addr, input string tag);
    logic [31:0] exp = model_load(addr, 4, 1'b0);
    int k = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    while (k < 40 && !bus.if_done) begin
      step();
      k++;
      if (k == 3) chk({tag, "_stall"}, 32'(bus.if_stall), 32'd1);
    end
    chk({tag, "_lat"}, 32'(k), 32'd6);
    chk({tag, "_inst"}, bus.if_inst, exp);
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic run_mem(input bit we, input logic [1:0] len, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int n = nbytes(len);
    int k = 0;
    int beats = 0;
    logic [31:0] exp = model_load(addr, n, sgn);
    bus.mem_req    = 1'b1;
    bus.mem_we     = we;
    bus.mem_len    = len;
    bus.mem_signed = sgn;
    bus.mem_addr   = addr;
    bus.mem_wdata  = wd;
    while (k < 40 && !bus.mem_done) begin
      step();
      k++;
      if (k == 1) chk({tag, "_stall"}, 32'(bus.mem_stall), 32'd1);
      if (bus.ram_wr) begin
        chk({tag, "_wa"}, bus.ram_a, addr + beats);
        chk({tag, "_wd"}, 32'(bus.ram_dout), (wd >> (8 * beats)) & 32'hFF);
        beats++;
      end
    end
    chk({tag, "_lat"}, 32'(k), we ? 32'(n + 1) : 32'(n + 2));
    if (we) begin
      chk({tag, "_beats"}, 32'(beats), 32'(n));
      model_store(addr, n, wd);
    end else begin
      chk({tag, "_rdata"}, bus.mem_rdata, exp);
    end
    bus.mem_req = 1'b0;
    step();
  endtask

  initial begin
    int k;
    bit early;
    logic [31:0] exp;

    for (int i = 0; i < 4096; i++) begin
      seed_mem[i] = 8'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
    poke(32'h300, 8'h80);
    poke(32'h310, 8'h01); poke(32'h311, 8'h80);

    rst = 1'b1; seed_en = 1'b1;
    bus.rdy = 1'b1; bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_signed = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) step();
    seed_en = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_done", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    chk("rst_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_a", bus.ram_a, 32'd0);
    chk("rst_dout", 32'(bus.ram_dout), 32'd0);
    chk("rst_data", bus.if_inst | bus.mem_rdata, 32'd0);

    // Instruction fetch alone.
    run_if(32'h100, "if_basic");
    chk("if_basic_const", bus.if_inst, 32'h00000513);

    // Both request: MEM first, IF accepted the cycle after mem_done.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_signed = 1'b0;
    bus.mem_addr = 32'h200;
    k = 0; early = 0;
    while (k < 40 && !bus.mem_done) begin
      step(); k++;
      if (bus.if_done) early = 1;
    end
    chk("arb_mem_lat", 32'(k), 32'd6);
    chk("arb_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
    chk("arb_if_stall", 32'(bus.if_stall), 32'd1);
    bus.mem_req = 1'b0;
    k = 0;
    while (k < 40 && !bus.if_done) begin step(); k++; end
    chk("arb_if_early", 32'(early), 32'd0);
    chk("arb_if_lat", 32'(k), 32'd7);
    chk("arb_if_inst", bus.if_inst, 32'h00000513);
    bus.if_req = 1'b0;
    step();

    // Extension cases.
    run_mem(1'b0, 2'd0, 1'b1, 32'h300, 32'h0, "ldb_s");
    chk("ldb_s_const", bus.mem_rdata, 32'hFFFFFF80);
    run_mem(1'b0, 2'd0, 1'b0, 32'h300, 32'h0, "ldb_u");
    chk("ldb_u_const", bus.mem_rdata, 32'h00000080);
    run_mem(1'b0, 2'd1, 1'b1, 32'h310, 32'h0, "ldh_s");
    chk("ldh_s_const", bus.mem_rdata, 32'hFFFF8001);

    // Word store then read back.
    run_mem(1'b1, 2'd3, 1'b0, 32'h400, 32'h11223344, "st_w");
    run_mem(1'b0, 2'd3, 1'b0, 32'h400, 32'h0, "st_w_rb");
    chk("st_w_rb_const", bus.mem_rdata, 32'h11223344);

    // Flush at cnt=2, then a new fetch accepted right away.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    early = 0;
    repeat (3) begin step(); if (bus.if_done) early = 1; end
    bus.if_flush = 1'b1;
    step();
    if (bus.if_done) early = 1;
    bus.if_flush = 1'b0; bus.if_addr = 32'h200;
    k = 0;
    while (k < 40 && !bus.if_done) begin step(); k++; end
    chk("flush_no_done", 32'(early), 32'd0);
    chk("flush_lat", 32'(k), 32'd6);
    chk("flush_inst", bus.if_inst, 32'hDEADBEEF);
    bus.if_req = 1'b0;
    step();

    // rdy low for 3 cycles in the middle of a word load.
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_signed = 1'b1;
    bus.mem_addr = 32'h200;
    step(); step();
    bus.rdy = 1'b0;
    repeat (3) step();
    bus.rdy = 1'b1;
    k = 5;
    while (k < 40 && !bus.mem_done) begin step(); k++; end
    chk("rdy_lat", 32'(k), 32'd9);
    chk("rdy_rdata", bus.mem_rdata, 32'hDEADBEEF);
    bus.mem_req = 1'b0;
    step();

    // Reset in the middle of a store: only the first byte lands.
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd3;
    bus.mem_addr = 32'h500; bus.mem_wdata = 32'h55667788;
    step(); step();
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(bus.ram_wr), 32'd0);
    bus.mem_req = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_mid_outs", {29'd0, bus.mem_done, bus.if_done, bus.ram_wr}, 32'd0);
    chk("rst_mid_a", bus.ram_a, 32'd0);
    chk("rst_mid_dout", 32'(bus.ram_dout), 32'd0);
    chk("rst_mid_rdata", bus.mem_rdata, 32'd0);
    chk("rst_mid_inst", bus.if_inst, 32'd0);
    model_store(32'h500, 1, 32'h55667788);
    early = 0;
    repeat (3) begin step(); if (bus.mem_done) early = 1; end
    chk("rst_mid_nodone", 32'(early), 32'd0);
    run_mem(1'b0, 2'd3, 1'b0, 32'h500, 32'h0, "rst_rb");

    // Random traffic, including wrap at the top of the address space.
    run_mem(1'b1, 2'd3, 1'b0, 32'hFFFFFFFE, $urandom, "wrap_st");
    run_mem(1'b0, 2'd3, 1'b0, 32'hFFFFFFFE, 32'h0, "wrap_ld");
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] a = $urandom;
      logic [1:0] len = 2'($urandom_range(0, 3));
      if (kind == 0) run_if(a, "rnd_if");
      else if (kind == 1) run_mem(1'b0, len, 1'($urandom_range(0, 1)), a, 32'h0, "rnd_ld");
      else run_mem(1'b1, len, 1'b0, a, $urandom, "rnd_st");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port, byte-serial memory controller shared by the instruction-fetch (IF) and memory-access (MEM) pipeline stages.
- Arbitrates the two requesters, sequences multi-byte reads and writes over an 8-bit RAM bus, and assembles or splits words.
- Drives if_stall and mem_stall into the pipeline stall controller.
- MEM has fixed priority over IF.

Parameters:
ADDR_W, 32, address width of requests and of the RAM bus

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes all state, forces mem_wr=0
if_req  in  1  IF requests 4-byte instruction read
if_addr  in  ADDR_W  instruction address
if_flush  in  1  abort any pending or in-flight IF read (branch redirect)
if_done  out  1  one-cycle pulse: if_inst valid
if_inst  out  32  fetched instruction, little-endian
mem_req  in  1  MEM requests load/store
mem_we  in  1  1=store, 0=load
mem_len  in  2  bytes-1 (0=byte, 1=half, 3=word; 2 illegal, treated as 3)
mem_signed  in  1  sign-extend load result
mem_addr  in  ADDR_W  data address
mem_wdata  in  32  store data, byte 0 written first
mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
mem_rdata  out  32  load result, zero/sign extended
if_stall  out  1  if_req & ~if_done
mem_stall  out  1  mem_req & ~mem_done
ram_din  in  8  RAM read data, valid one cycle after address
ram_dout  out  8  RAM write data
ram_a  out  ADDR_W  RAM byte address
ram_wr  out  1  1=write this cycle

Behaviour:
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt (3 bits). Latched base address, length N (1/2/4), signed flag, 32-bit data buffer.
- Reset: state=IDLE, cnt=0, buffer=0; if_done=0, mem_done=0, if_inst=0, mem_rdata=0, ram_wr=0, ram_a=0, ram_dout=0.
- IDLE accept cycle: mem_req → latch, enter MEM_RD/MEM_WR; else if_req & ~if_flush → enter IF_RD. Both requesting → MEM wins, IF stays stalled.
- Reads (N bytes), cnt=0..N:
  - for cnt<N, ram_a=base+cnt;
  - for cnt≥1, buffer byte[cnt-1] ← ram_din;
  - at cnt=N: pulse done next cycle with assembled data, return IDLE.
  - Latency from accept: N+2 cycles to done (word: 6).
- Writes, cnt=0..N-1: ram_wr=1, ram_a=base+cnt, ram_dout=wdata byte[cnt]; at cnt=N-1 pulse mem_done next cycle, return IDLE. Word store: 5 cycles accept→done.
- ram_a/ram_dout/ram_wr are combinational from state/cnt/latched values. Outside active cycles: ram_wr=0, ram_a holds last value.
- Load extension: N=1 extends bit 7; N=2 extends bit 15; N=4 none.
- if_flush during IF_RD: return to IDLE next cycle, no if_done, buffer discarded. if_flush with if_done pulsing: suppress the pulse.
- MEM transactions are never aborted. if_flush has no effect on them.
- A done pulse lasts exactly one cycle. The requester drops or changes req in the done cycle. The next accept can occur in the cycle after done.
- rdy=0: hold state, cnt, outputs except ram_wr=0; a read byte in flight is re-fetched after resume (address reissued at same cnt).
- Reset mid-transaction: abort, no done pulse, ram_wr=0 same cycle.
- Address arithmetic: base+cnt, modulo 2^ADDR_W (wrap permitted).

Decomposition:
- Shared package: state encoding, mem_len encodings (LEN_B=0, LEN_H=1, LEN_W=3).
- Sub-module ld_ext (combinational byte/half/word zero/sign extension), reusable by the MEM stage.

Test Plan:
- IF only, if_addr=0x100, RAM bytes 13 05 00 00 → if_done in cycle 6 after accept, if_inst=0x00000513, if_stall high until done.
- Simultaneous if_req and mem_req (load word @0x200=0xDEADBEEF) → MEM served first, mem_rdata=0xDEADBEEF; IF accepted the cycle after mem_done.
- Signed byte load @0x300=0x80 → mem_rdata=0xFFFFFF80; unsigned → 0x00000080; signed half 0x8001 → 0xFFFF8001.
- Word store 0x11223344 @0x400 → ram_wr 4 cycles, addresses 0x400..0x403, data 44 33 22 11, then mem_done.
- if_flush at cnt=2 of IF read → no if_done, back to IDLE; new if_req accepted next cycle.
- rdy=0 for 3 cycles mid word load; rst mid store → result unchanged / ram_wr=0 immediately, all outputs at reset values.
